// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the sync generator and the board renderer.
package vga_timing_pkg;
  localparam int COORD_W   = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam bit SYNC_POL  = 1'b0;

  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with increment enable; wrap is high on the clock that returns it to 0.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int MODULUS = 800
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap
);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(MODULUS - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk25) begin
    if (rst)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: free-running h/v counters followed by one registered decode stage,
// so coordinates, syncs and flags all lag the counters by exactly one clock.
module vga_sync_gen
  import vga_timing_pkg::COORD_W;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
  input  logic               clk25,
  input  logic               rst,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic               line_start
);
  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_bad_timing
    $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
  end

  // One extra bit so a sync end equal to 2**COORD_W still compares correctly.
  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] H_VIS_E = CW1'(H_VISIBLE);
  localparam logic [CW1-1:0] HS_BEG  = CW1'(H_VISIBLE + H_FP);
  localparam logic [CW1-1:0] HS_END  = CW1'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] V_VIS_E = CW1'(V_VISIBLE);
  localparam logic [CW1-1:0] VS_BEG  = CW1'(V_VISIBLE + V_FP);
  localparam logic [CW1-1:0] VS_END  = CW1'(V_VISIBLE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap_unused;
  logic [CW1-1:0]     hx, vy;

  mod_counter #(.MODULUS(H_TOT)) u_hcnt (
    .clk25(clk25), .rst(rst), .en(1'b1),   .cnt(h_cnt), .wrap(h_wrap)
  );
  mod_counter #(.MODULUS(V_TOT)) u_vcnt (
    .clk25(clk25), .rst(rst), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap_unused)
  );

  assign hx = {1'b0, h_cnt};
  assign vy = {1'b0, v_cnt};

  always_ff @(posedge clk25) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      video_on    <= (hx < H_VIS_E) && (vy < V_VIS_E);
      hsync       <= (hx >= HS_BEG && hx < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (vy >= VS_BEG && vy < VS_END) ? SYNC_POL : ~SYNC_POL;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end
endmodule
